// File: rtl/shift_pkg.sv
// Shared types, default widths and range helper for the pipelined shift unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL  = 2'd0,
    SRL  = 2'd1,
    SRA  = 2'd2,
    PASS = 2'd3
  } shift_op_t;

  localparam int unsigned DefN    = 32;
  localparam int unsigned DefSW   = 6;
  localparam int unsigned DefTagW = 4;

  // Callers zero-extend the shift amount to 32 bits.
  function automatic logic is_oor(input logic [31:0] s, input int unsigned n);
    return s >= n;
  endfunction

endpackage

// File: rtl/shift_core.sv
// Combinational shifter: SLL / SRL / SRA / PASS.
// Out-of-range amounts produce zero and raise oor.
module shift_core
  import shift_pkg::*;
#(
  parameter int unsigned N   = DefN,
  parameter int unsigned S_W = DefSW
) (
  input  shift_op_t      op,
  input  logic [N-1:0]   a,
  input  logic [S_W-1:0] s,
  output logic [N-1:0]   y,
  output logic           oor
);

  logic range_oor;
  assign range_oor = is_oor(32'(s), N);

  always_comb begin
    y   = '0;
    oor = 1'b0;
    unique case (op)
      SLL:  y = a << s;
      SRL:  y = a >> s;
      SRA:  y = N'($signed(a) >>> s);
      PASS: y = a;
    endcase
    // SRA must not sign-fill here: out-of-range shifts always give zero.
    if (op != PASS && range_oor) begin
      y   = '0;
      oor = 1'b1;
    end
  end

endmodule

// File: rtl/shift_unit_pipe.sv
// Two-stage valid/ready shift unit: stage 1 holds operands, stage 2 holds the result.
// Full throughput; in_ready is combinational from out_ready (no skid buffer).
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned N     = DefN,
  parameter int unsigned S_W   = DefSW,
  parameter int unsigned TAG_W = DefTagW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  shift_op_t        in_op,
  input  logic [N-1:0]     in_a,
  input  logic [S_W-1:0]   in_s,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     out_y,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_oor
);

  logic             s1_valid_q;
  shift_op_t        s1_op_q;
  logic [N-1:0]     s1_a_q;
  logic [S_W-1:0]   s1_s_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q;
  logic [N-1:0]     s2_y_q;
  logic [TAG_W-1:0] s2_tag_q;
  logic             s2_oor_q;

  logic             s1_adv;
  logic             s2_adv;
  logic             in_fire;
  logic [N-1:0]     core_y;
  logic             core_oor;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign s1_adv   = !s1_valid_q || s2_adv;
  assign in_ready = s1_adv;
  assign in_fire  = in_valid && s1_adv;

  shift_core #(
    .N   (N),
    .S_W (S_W)
  ) u_core (
    .op  (s1_op_q),
    .a   (s1_a_q),
    .s   (s1_s_q),
    .y   (core_y),
    .oor (core_oor)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q <= 1'b0;
      s1_op_q    <= SLL;
      s1_a_q     <= '0;
      s1_s_q     <= '0;
      s1_tag_q   <= '0;
    end else begin
      if (s1_adv) s1_valid_q <= in_valid;
      if (in_fire) begin
        s1_op_q  <= in_op;
        s1_a_q   <= in_a;
        s1_s_q   <= in_s;
        s1_tag_q <= in_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid_q <= 1'b0;
      s2_y_q     <= '0;
      s2_tag_q   <= '0;
      s2_oor_q   <= 1'b0;
    end else begin
      if (s2_adv) s2_valid_q <= s1_valid_q;
      // Only load on a real op so the outputs keep their last value across bubbles.
      if (s2_adv && s1_valid_q) begin
        s2_y_q   <= core_y;
        s2_tag_q <= s1_tag_q;
        s2_oor_q <= core_oor;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_y     = s2_y_q;
  assign out_tag   = s2_tag_q;
  assign out_oor   = s2_oor_q;

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Self-checking bench for shift_unit_pipe: directed vectors plus a queue-based reference model.
module tb_shift_unit_pipe;
  import shift_pkg::*;

  localparam int unsigned N     = 32;
  localparam int unsigned S_W   = 6;
  localparam int unsigned TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  shift_op_t        in_op = SLL;
  logic [N-1:0]     in_a = '0;
  logic [S_W-1:0]   in_s = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [N-1:0]     out_y;
  logic [TAG_W-1:0] out_tag;
  logic             out_oor;

  always #5 clk = ~clk;

  shift_unit_pipe #(
    .N     (N),
    .S_W   (S_W),
    .TAG_W (TAG_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_s      (in_s),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_y     (out_y),
    .out_tag   (out_tag),
    .out_oor   (out_oor)
  );

  typedef struct packed {
    logic [N-1:0]     y;
    logic [TAG_W-1:0] tag;
    logic             oor;
  } res_t;

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;
  int          n_in = 0;
  int          n_out = 0;
  res_t        exp_q[$];
  res_t        exp_r;
  res_t        prev;
  logic        prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: shifts by the arithmetic rules, SRA built from a logical shift plus sign fill.
  function automatic res_t model(shift_op_t op, logic [N-1:0] a, logic [S_W-1:0] s,
                                 logic [TAG_W-1:0] tag);
    res_t        r;
    int unsigned sh;
    sh    = int'(s);
    r.tag = tag;
    r.oor = 1'b0;
    r.y   = '0;
    if (op == PASS) r.y = a;
    else if (sh >= N) r.oor = 1'b1;
    else begin
      case (op)
        SLL:     r.y = a << sh;
        SRL:     r.y = a >> sh;
        default: begin
          r.y = a >> sh;
          if (a[N-1]) r.y = r.y | ~({N{1'b1}} >> sh);
        end
      endcase
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on output transfer, push on input transfer, verify stability while stalled.
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 64'(out_valid), 64'(1));
        check("stall_y", 64'(out_y), 64'(prev.y));
        check("stall_tag", 64'(out_tag), 64'(prev.tag));
        check("stall_oor", 64'(out_oor), 64'(prev.oor));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out: got tag %0h expected no result", out_tag);
        end else begin
          exp_r = exp_q.pop_front();
          check("sb_y", 64'(out_y), 64'(exp_r.y));
          check("sb_tag", 64'(out_tag), 64'(exp_r.tag));
          check("sb_oor", 64'(out_oor), 64'(exp_r.oor));
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev.y     = out_y;
      prev.tag   = out_tag;
      prev.oor   = out_oor;
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_op, in_a, in_s, in_tag));
        n_in++;
      end
    end
  end

  // Present one op and return just after the edge that accepts it.
  task automatic send(input shift_op_t op, input logic [N-1:0] a, input logic [S_W-1:0] s,
                      input logic [TAG_W-1:0] tag);
    logic acc;
    int   n;
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_s     = s;
    in_tag   = tag;
    n        = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 1000);
    if (!acc) check("send_timeout", 64'(0), 64'(1));
    in_valid = 1'b0;
  endtask

  // Op into an empty pipe with out_ready=1: visible one edge after accept, gone the next.
  task automatic directed(input string name, input shift_op_t op, input logic [N-1:0] a,
                          input logic [S_W-1:0] s, input logic [TAG_W-1:0] tag,
                          input logic [N-1:0] exp_y, input logic exp_oor);
    send(op, a, s, tag);
    check({name, "_early"}, 64'(out_valid), 64'(0));
    @(posedge clk);
    #1;
    check({name, "_valid"}, 64'(out_valid), 64'(1));
    check({name, "_y"}, 64'(out_y), 64'(exp_y));
    check({name, "_tag"}, 64'(out_tag), 64'(tag));
    check({name, "_oor"}, 64'(out_oor), 64'(exp_oor));
    @(posedge clk);
    #1;
    check({name, "_gone"}, 64'(out_valid), 64'(0));
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while ((exp_q.size() != 0 || out_valid) && n < 200);
    check({name, "_drained"}, 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          base_in;
    int          base_out;
    int unsigned t0;
    int unsigned done_edge;
    int          n;
    logic        done;
    res_t        m;

    // Model pinned against hand-computed values.
    m = model(SRA, 32'h8000_0000, 6'd4, 4'h0);
    check("model_sra", 64'(m.y), 64'(32'hF800_0000));
    m = model(SRA, 32'hFFFF_FFFF, 6'd40, 4'h0);
    check("model_sra_oor", 64'({m.y, m.oor}), 64'({32'h0, 1'b1}));
    m = model(SRL, 32'h8000_0000, 6'd4, 4'h0);
    check("model_srl", 64'(m.y), 64'(32'h0800_0000));

    // Reset state.
    #12;
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_y", 64'(out_y), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
    check("rst_out_oor", 64'(out_oor), 64'(0));
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    check("rel_in_ready", 64'(in_ready), 64'(1));

    // Basic ops and boundaries.
    directed("sll31", SLL, 32'h0000_0001, 6'd31, 4'h1, 32'h8000_0000, 1'b0);
    directed("srl4", SRL, 32'h8000_0000, 6'd4, 4'h2, 32'h0800_0000, 1'b0);
    directed("sra4", SRA, 32'h8000_0000, 6'd4, 4'h3, 32'hF800_0000, 1'b0);
    directed("sra31", SRA, 32'h8000_0000, 6'd31, 4'h4, 32'hFFFF_FFFF, 1'b0);
    directed("sra0", SRA, 32'h8765_4321, 6'd0, 4'h5, 32'h8765_4321, 1'b0);
    directed("sra40", SRA, 32'hFFFF_FFFF, 6'd40, 4'h6, 32'h0000_0000, 1'b1);
    directed("sll32", SLL, 32'h1234_5678, 6'd32, 4'h7, 32'h0000_0000, 1'b1);
    directed("srl63", SRL, 32'hFFFF_FFFF, 6'd63, 4'h8, 32'h0000_0000, 1'b1);
    directed("pass63", PASS, 32'hDEAD_BEEF, 6'd63, 4'h9, 32'hDEAD_BEEF, 1'b0);

    // Backpressure: 4 ops, out_ready low for 5 cycles.
    base_out  = n_out;
    out_ready = 1'b0;
    fork
      begin
        for (int t = 0; t < 4; t++) send(SRL, 32'hF000_0000, 6'(t), 4'(t));
      end
      begin
        repeat (2) @(posedge clk);
        #2;
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_valid", 64'(out_valid), 64'(1));
        check("bp_tag0", 64'(out_tag), 64'(0));
        repeat (3) begin
          @(posedge clk);
          #2;
          check("bp_in_ready_hold", 64'(in_ready), 64'(0));
          check("bp_y_hold", 64'(out_y), 64'(32'hF000_0000));
        end
        out_ready = 1'b1;
      end
    join
    drain("bp");
    check("bp_count", 64'(n_out - base_out), 64'(4));

    // Throughput: 100 back-to-back ops.
    base_out = n_out;
    t0       = cyc;
    for (int i = 0; i < 100; i++)
      send(shift_op_t'($urandom_range(0, 3)), $urandom, 6'($urandom_range(0, 40)), 4'(i));
    check("tp_accept_cycles", 64'(cyc - t0), 64'(100));
    n = 0;
    do begin
      @(negedge clk);
      #1;
      n++;
    end while (n_out - base_out < 100 && n < 50);
    done_edge = cyc + 1;
    check("tp_total_cycles", 64'(done_edge - t0), 64'(102));
    drain("tp");

    // Random valid/ready toggling.
    base_in  = n_in;
    base_out = n_out;
    done     = 1'b0;
    fork
      begin
        for (int i = 0; i < 1024; i++) begin
          if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
          #0;
          send(shift_op_t'($urandom_range(0, 3)),
               ($urandom_range(0, 3) == 0) ? 32'h8000_0001 : $urandom,
               ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 31)),
               4'(i));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom_range(0, 3) != 0);
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    drain("rnd");
    check("rnd_in_count", 64'(n_in - base_in), 64'(1024));
    check("rnd_out_count", 64'(n_out - base_out), 64'(1024));

    // Reset with two ops in flight.
    out_ready = 1'b0;
    send(SLL, 32'h0000_00FF, 6'd4, 4'hA);
    send(SRL, 32'h0000_FF00, 6'd4, 4'hB);
    #3;
    rst = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'(0));
    check("mid_rst_y", 64'(out_y), 64'(0));
    check("mid_rst_tag", 64'(out_tag), 64'(0));
    @(posedge clk);
    @(posedge clk);
    #1;
    rst       = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_no_stale", 64'(out_valid), 64'(0));
    end
    directed("post_rst", SRA, 32'hF000_000F, 6'd8, 4'hC, 32'hFFF0_0000, 1'b0);
    drain("end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
